// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: packs table-driven Huffman codes MSB-first into W-bit words and
// serves them from a small FIFO on request. Define HUFF_PACK_STATS_EN for symbol/bit counters.
module huffman_bit_packer #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] sym_in,
   input  logic         sym_valid,
   output logic         sym_ready,
   input  logic         flush,
   output logic         flush_done,
   input  logic [W-1:0] d_conf,
   input  logic [W-1:0] h_conf,
   input  logic [W-1:0] w_conf,
   input  logic         en_conf,
   input  logic         new_conf,
   input  logic         d_req,
   output logic [W-1:0] d_out,
   output logic         en_out,
   output logic         ready_out,
`ifdef HUFF_PACK_STATS_EN
   output logic [31:0]  stat_syms,
   output logic [31:0]  stat_bits,
`endif
   output logic         err_uncfg
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [4:0] W_F     = 5'(W);
   localparam logic [4:0] ACC_W   = 5'(2 * W);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

   state_t state, state_nxt;

   logic [W-1:0]      code_mem  [2**W];
   logic [3:0]        width_mem [2**W];
   logic [2**W-1:0]   tbl_vld;

   logic [2*W-1:0]    acc, acc_add, acc_nxt, ins;
   logic [4:0]        fill, fill_nxt, sym_w, shamt;
   logic [W-1:0]      code_mask;

   logic [W-1:0]      fifo_mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr, fifo_cnt;

   logic conf_wr, accept, sym_hit, add, pop, fifo_full, room;
   logic norm_push, pad_push, push;

   assign conf_wr = en_conf && !new_conf && (w_conf >= W'(2)) && (w_conf <= W'(8));

   always_ff @(posedge clk) begin
      if (conf_wr) begin
         code_mem[d_conf]  <= h_conf;
         width_mem[d_conf] <= w_conf[3:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               tbl_vld <= '0;
      else if (new_conf)      tbl_vld <= '0;
      else if (conf_wr)       tbl_vld[d_conf] <= 1'b1;
   end

   // Lookup and placement: the code lands just below the bits already held.
   assign sym_ready = (state == RUN) && (fill < W_F) && !en_conf && !new_conf;
   assign accept    = sym_valid && sym_ready;
   assign sym_hit   = tbl_vld[sym_in];
   assign add       = accept && sym_hit;
   assign sym_w     = {1'b0, width_mem[sym_in]};
   assign code_mask = ~({W{1'b1}} << sym_w);
   assign shamt     = ACC_W - fill - sym_w;
   assign ins       = {{W{1'b0}}, code_mem[sym_in] & code_mask} << shamt;
   assign acc_add   = add ? (acc | ins) : acc;

   assign fifo_cnt  = wr_ptr - rd_ptr;
   assign fifo_full = (fifo_cnt == DEPTH_C);
   assign ready_out = (fifo_cnt != '0);
   assign pop       = d_req && ready_out;
   assign room      = !fifo_full || pop;
   assign norm_push = (fill >= W_F) && room;
   // Bits below fill are always zero, so the top word already carries the pad.
   assign pad_push  = (state == FLUSH) && (fill != 5'd0) && (fill < W_F) && room;
   assign push      = norm_push || pad_push;

   always_comb begin
      acc_nxt  = acc_add;
      fill_nxt = fill - (norm_push ? W_F : 5'd0) + (add ? sym_w : 5'd0);
      if (pad_push) begin
         acc_nxt  = '0;
         fill_nxt = 5'd0;
      end else if (norm_push) begin
         acc_nxt = acc_add << W;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush) state_nxt = FLUSH;
         FLUSH:   if (fill == 5'd0 || pad_push) state_nxt = DONE;
         DONE:    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign flush_done = (state == DONE);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= acc[2*W-1:W];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         acc       <= '0;
         fill      <= 5'd0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         en_out    <= 1'b0;
         d_out     <= '0;
         err_uncfg <= 1'b0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         fill   <= fill_nxt;
         en_out <= pop;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            d_out  <= fifo_mem[rd_ptr[AW-1:0]];
         end
         if (new_conf)                 err_uncfg <= 1'b0;
         else if (accept && !sym_hit)  err_uncfg <= 1'b1;
      end
   end

`ifdef HUFF_PACK_STATS_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? '1 : sum[31:0];
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_syms <= '0;
         stat_bits <= '0;
      end else if (new_conf) begin
         stat_syms <= '0;
         stat_bits <= '0;
      end else if (add) begin
         stat_syms <= sat_add(stat_syms, 32'd1);
         stat_bits <= sat_add(stat_bits, {27'd0, sym_w});
      end
   end
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb_huffman_bit_packer: vector table, directed corner sequences and a randomized run
// checked against a bit-queue model of the packed stream.
`timescale 1ns/1ps
module tb_huffman_bit_packer;
   localparam int W     = 8;
   localparam int DEPTH = 4;

   logic         clk = 1'b0, rst = 1'b0;
   logic [W-1:0] sym_in = '0, d_conf = '0, h_conf = '0, w_conf = '0;
   logic         sym_valid = 1'b0, flush = 1'b0, en_conf = 1'b0, new_conf = 1'b0, d_req = 1'b0;
   logic         sym_ready, flush_done, en_out, ready_out, err_uncfg;
   logic [W-1:0] d_out;
`ifdef HUFF_PACK_STATS_EN
   logic [31:0]  stat_syms, stat_bits;
`endif
   int n_run = 0, n_fail = 0;

   always #5 clk = ~clk;

   huffman_bit_packer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .flush(flush), .flush_done(flush_done), .d_conf(d_conf), .h_conf(h_conf),
      .w_conf(w_conf), .en_conf(en_conf), .new_conf(new_conf), .d_req(d_req),
      .d_out(d_out), .en_out(en_out), .ready_out(ready_out),
`ifdef HUFF_PACK_STATS_EN
      .stat_syms(stat_syms), .stat_bits(stat_bits),
`endif
      .err_uncfg(err_uncfg)
   );

   typedef struct {
      logic [7:0] code;
      logic [7:0] w;
      logic [7:0] exp;
   } vec_t;

   logic [7:0] exp_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [7:0] s, input logic [7:0] c, input logic [7:0] w);
      d_conf = s; h_conf = c; w_conf = w; en_conf = 1'b1;
      tick();
      en_conf = 1'b0;
   endtask

   task automatic clear_tbl();
      new_conf = 1'b1;
      tick();
      new_conf = 1'b0;
   endtask

   task automatic send(input logic [7:0] s, input string nm);
      bit ok = 1'b0;
      sym_in = s; sym_valid = 1'b1;
      for (int k = 0; k < 40 && !ok; k++) begin
         #1;
         if (sym_ready) ok = 1'b1;
         tick();
      end
      sym_valid = 1'b0;
      chk({nm, " accepted"}, 32'(ok), 32'd1);
   endtask

   task automatic do_flush(input string nm);
      bit seen = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (flush_done) seen = 1'b1;
         else tick();
      end
      chk({nm, " flush_done"}, 32'(seen), 32'd1);
      if (seen) begin
         tick();
         chk({nm, " flush_done one cycle"}, 32'(flush_done), 32'd0);
      end
   endtask

   task automatic req(input logic [7:0] exp, input string nm);
      d_req = 1'b1;
      tick();
      d_req = 1'b0;
      chk({nm, " en_out"}, 32'(en_out), 32'd1);
      chk({nm, " d_out"}, 32'(d_out), 32'(exp));
      tick();
      chk({nm, " en_out low"}, 32'(en_out), 32'd0);
   endtask

   task automatic check_word();
      if (exp_q.size() == 0) chk("rand unexpected word", 32'(en_out), 32'd0);
      else chk("rand word", 32'(d_out), 32'(exp_q.pop_front()));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [7];
      logic [7:0] rcode [16];
      int         rw [16];
      bit         rok [16];
      logic [7:0] seq [$];
      bit         bits_q [$];
      bit         exp_err = 1'b0;
      logic [7:0] word;
      int         idx;
      bit         took;

      vt[0] = '{8'h03, 8'd2, 8'hC0};
      vt[1] = '{8'h05, 8'd3, 8'hA0};
      vt[2] = '{8'h00, 8'd9, 8'hA0};
      vt[3] = '{8'hA5, 8'd8, 8'hA5};
      vt[4] = '{8'h00, 8'd1, 8'hA5};
      vt[5] = '{8'hFF, 8'd5, 8'hF8};
      vt[6] = '{8'h7F, 8'd7, 8'hFE};

      // Reset values
      tick(); tick();
      chk("reset sym_ready", 32'(sym_ready), 32'd1);
      chk("reset ready_out", 32'(ready_out), 32'd0);
      chk("reset en_out", 32'(en_out), 32'd0);
      chk("reset flush_done", 32'(flush_done), 32'd0);
      chk("reset err_uncfg", 32'(err_uncfg), 32'd0);
      chk("reset d_out", 32'(d_out), 32'd0);
      rst = 1'b1;
      tick();

      // A,B,A then flush: 10 011 10 padded with one zero
      cfg(8'h41, 8'h02, 8'd2);
      cfg(8'h42, 8'h03, 8'd3);
      cfg(8'h43, 8'h35, 8'd6);
      send(8'h41, "ABA A"); send(8'h42, "ABA B"); send(8'h41, "ABA A2");
      chk("ABA partial not pushed", 32'(ready_out), 32'd0);
      do_flush("ABA");
      chk("ABA ready_out", 32'(ready_out), 32'd1);
      req(8'h9C, "ABA word");
      chk("ABA fifo drained", 32'(ready_out), 32'd0);

      // Unconfigured symbol
      send(8'h7F, "uncfg");
      chk("uncfg err set", 32'(err_uncfg), 32'd1);
      chk("uncfg no push", 32'(ready_out), 32'd0);
      clear_tbl();
      chk("uncfg err cleared", 32'(err_uncfg), 32'd0);

      // Table-driven single-symbol words, including ignored widths and masked code bits
      for (int i = 0; i < 7; i++) begin
         cfg(8'h30, vt[i].code, vt[i].w);
         send(8'h30, $sformatf("vec%0d", i));
         do_flush($sformatf("vec%0d", i));
         req(vt[i].exp, $sformatf("vec%0d", i));
      end

      // FIFO full backpressure
      cfg(8'h10, 8'hFF, 8'd8);
      for (int i = 0; i < DEPTH + 1; i++) send(8'h10, $sformatf("full sym%0d", i));
      tick(); tick();
      chk("full sym_ready stalled", 32'(sym_ready), 32'd0);
      chk("full ready_out", 32'(ready_out), 32'd1);
      req(8'hFF, "full word0");
      send(8'h10, "full sym last");
      for (int i = 1; i < DEPTH + 2; i++) req(8'hFF, $sformatf("full word%0d", i));
      chk("full drained", 32'(ready_out), 32'd0);

      // Request on empty FIFO is dropped
      d_req = 1'b1; tick(); d_req = 1'b0;
      chk("empty req en_out", 32'(en_out), 32'd0);
      chk("empty req ready_out", 32'(ready_out), 32'd0);

      // Two 7-bit codes: one word pushed, tail padded on flush
      cfg(8'h20, 8'h55, 8'd7);
      send(8'h20, "7b first"); send(8'h20, "7b second");
      do_flush("7b");
      req(8'hAB, "7b word0");
      req(8'h54, "7b word1");

      // Reset while the flush is stalled behind a full FIFO
      send(8'h7F, "rst uncfg");
      for (int i = 0; i < DEPTH + 1; i++) send(8'h10, $sformatf("rst sym%0d", i));
      flush = 1'b1; tick(); flush = 1'b0; tick();
      chk("rst pre flush_done", 32'(flush_done), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("rst async sym_ready", 32'(sym_ready), 32'd1);
      chk("rst async ready_out", 32'(ready_out), 32'd0);
      chk("rst async d_out", 32'(d_out), 32'd0);
      chk("rst async err_uncfg", 32'(err_uncfg), 32'd0);
      chk("rst async flush_done", 32'(flush_done), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      send(8'h10, "post rst stale");
      chk("post rst valid cleared", 32'(err_uncfg), 32'd1);
      chk("post rst nothing packed", 32'(ready_out), 32'd0);
      cfg(8'h10, 8'h81, 8'd8);
      send(8'h10, "post rst");
      tick();
      req(8'h81, "post rst word");
      chk("post rst drained", 32'(ready_out), 32'd0);

      // Randomized stream against a bit-queue model
      clear_tbl();
      for (int i = 0; i < 16; i++) begin
         rw[i]    = $urandom_range(8, 2);
         rcode[i] = 8'($urandom);
         rok[i]   = ($urandom_range(4, 0) != 0);
         if (rok[i]) cfg(8'(8'h80 + i), rcode[i], 8'(rw[i]));
         else        cfg(8'(8'h80 + i), rcode[i], 8'($urandom_range(1, 0)));
      end
      for (int n = 0; n < 80; n++) begin
         int s;
         s = $urandom_range(15, 0);
         seq.push_back(8'(8'h80 + s));
         if (rok[s]) for (int b = rw[s] - 1; b >= 0; b--) bits_q.push_back(rcode[s][b]);
         else exp_err = 1'b1;
      end
      while (bits_q.size() > 0) begin
         word = '0;
         for (int b = 7; b >= 0; b--) if (bits_q.size() > 0) word[b] = bits_q.pop_front();
         exp_q.push_back(word);
      end

      idx = 0;
      for (int c = 0; c < 4000 && idx < seq.size(); c++) begin
         sym_valid = ($urandom_range(3, 0) != 0);
         sym_in    = seq[idx];
         d_req     = ($urandom_range(2, 0) == 0);
         #1;
         took = sym_valid && sym_ready;
         tick();
         if (took) idx++;
         if (en_out) check_word();
      end
      sym_valid = 1'b0;
      chk("rand all symbols sent", 32'(idx), 32'(seq.size()));
      flush = 1'b1; d_req = 1'b1;
      tick();
      flush = 1'b0;
      if (en_out) check_word();
      for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
         d_req = 1'b1;
         tick();
         if (en_out) check_word();
      end
      d_req = 1'b0;
      tick();
      chk("rand no extra word", 32'(en_out), 32'd0);
      chk("rand words remaining", 32'(exp_q.size()), 32'd0);
      chk("rand fifo empty", 32'(ready_out), 32'd0);
      chk("rand err_uncfg", 32'(err_uncfg), 32'(exp_err));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
